// File: rtl/pipeline_stall_regs_pkg.sv
// cpu_pkg: shared definitions for the pipeline register slice.
//   - Control-vector bit positions for the 9-bit ID/EX control word
//     {RegWrite, MemtoReg, MemRead, MemWrite, Branch, ALUSrc, RegDst, ALUOp[1:0]}
//   - NOP encoding (sll $0,$0,0 == all zeros)
//   - MIPS register-field slice positions
//   - Stall FSM state type and field-extraction helpers
package cpu_pkg;

    localparam int CTRL_W        = 9;
    localparam int CTRL_REGWRITE = 8;
    localparam int CTRL_MEMTOREG = 7;
    localparam int CTRL_MEMREAD  = 6;
    localparam int CTRL_MEMWRITE = 5;
    localparam int CTRL_BRANCH   = 4;
    localparam int CTRL_ALUSRC   = 3;
    localparam int CTRL_REGDST   = 2;
    localparam int CTRL_ALUOP    = 0;   // ALUOp occupies [1:0]

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;
    localparam int RD_HI = 15;
    localparam int RD_LO = 11;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } stall_state_e;

    function automatic logic [4:0] field_rs(input logic [31:0] instr);
        return instr[RS_HI:RS_LO];
    endfunction

    function automatic logic [4:0] field_rt(input logic [31:0] instr);
        return instr[RT_HI:RT_LO];
    endfunction

    function automatic logic [4:0] field_rd(input logic [31:0] instr);
        return instr[RD_HI:RD_LO];
    endfunction

endpackage

// File: rtl/pipeline_stall_regs_if.sv
// Hazard-unit handshake bundle.
//   master (hazard unit): drives PCWrite, IF_ID_Write, Mux_Select_Stall;
//                         observes ID_EX_MemRead, ID_EX_RegRt, IF_ID_RegRs, IF_ID_RegRt.
//   slave  (pipeline regs): the reverse.
interface pipeline_stall_regs_if;
    logic       PCWrite;
    logic       IF_ID_Write;
    logic       Mux_Select_Stall;
    logic       ID_EX_MemRead;
    logic [4:0] ID_EX_RegRt;
    logic [4:0] IF_ID_RegRs;
    logic [4:0] IF_ID_RegRt;

    modport master (
        output PCWrite, IF_ID_Write, Mux_Select_Stall,
        input  ID_EX_MemRead, ID_EX_RegRt, IF_ID_RegRs, IF_ID_RegRt
    );

    modport slave (
        input  PCWrite, IF_ID_Write, Mux_Select_Stall,
        output ID_EX_MemRead, ID_EX_RegRt, IF_ID_RegRs, IF_ID_RegRt
    );
endinterface

// File: rtl/pipeline_stall_regs_pipe_reg_en.sv
// pipe_reg_en: generic pipeline register.
//   clk, rst (async active-high, loads RESET_VAL), en (load d),
//   clr (synchronous clear to zero, wins over en), d -> q.
module pipe_reg_en #(
    parameter int             W         = 32,
    parameter logic [W-1:0]   RESET_VAL = {W{1'b0}}
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Storage with clear-over-load priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (clr) begin
            q <= {W{1'b0}};
        end else if (en) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/pipeline_stall_regs.sv
// pipeline_stall_regs: PC, IF/ID and ID/EX registers acting on load-use
// hazard controls, plus a stall-tracking FSM and saturating stall counter.
//   clk, reset         : clock, async active-high reset
//   hz (slave)         : hazard controls in, compare fields out
//   Flush              : branch/jump redirect (beats every stall control)
//   PC_next, IF_Instr  : fetch-side inputs
//   ID_*               : decode-side inputs captured into ID/EX
//   PC, IF_ID_*, ID_EX_* : register outputs
//   Stall_Active, Stall_Count : stall observability
module pipeline_stall_regs
    import cpu_pkg::*;
#(
    parameter int                WIDTH    = 32,
    parameter int                CNT_W    = 16,
    parameter logic [WIDTH-1:0]  RESET_PC = {WIDTH{1'b0}}
) (
    input  logic                 clk,
    input  logic                 reset,
    pipeline_stall_regs_if.slave hz,
    input  logic                 Flush,
    input  logic [WIDTH-1:0]     PC_next,
    input  logic [WIDTH-1:0]     IF_Instr,
    input  logic [CTRL_W-1:0]    ID_Ctrl,
    input  logic [WIDTH-1:0]     ID_ReadData1,
    input  logic [WIDTH-1:0]     ID_ReadData2,
    input  logic [WIDTH-1:0]     ID_SignExt,
    output logic [WIDTH-1:0]     PC,
    output logic [WIDTH-1:0]     IF_ID_PC4,
    output logic [WIDTH-1:0]     IF_ID_Instr,
    output logic [CTRL_W-1:0]    ID_EX_Ctrl,
    output logic [4:0]           ID_EX_RegRs,
    output logic [4:0]           ID_EX_RegRd,
    output logic [WIDTH-1:0]     ID_EX_PC4,
    output logic [WIDTH-1:0]     ID_EX_ReadData1,
    output logic [WIDTH-1:0]     ID_EX_ReadData2,
    output logic [WIDTH-1:0]     ID_EX_SignExt,
    output logic                 Stall_Active,
    output logic [CNT_W-1:0]     Stall_Count
);

    localparam int IFID_W = 2 * WIDTH;
    localparam int IDEX_W = 4 * WIDTH + 15;

    logic                 stall_hit_s;
    logic                 pc_en_s;
    logic                 bubble_s;
    logic [WIDTH-1:0]     pc_plus4_s;
    logic [IFID_W-1:0]    ifid_d_s;
    logic [IFID_W-1:0]    ifid_q_s;
    logic [IDEX_W-1:0]    idex_d_s;
    logic [IDEX_W-1:0]    idex_q_s;
    logic [4:0]           idex_rt_s;
    stall_state_e         state_r;
    logic                 stall_active_r;
    logic [CNT_W-1:0]     stall_count_r;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // A stall only counts when it is not swallowed by a redirect.
    assign stall_hit_s = hz.Mux_Select_Stall & ~Flush;
    assign pc_en_s     = Flush | hz.PCWrite;
    assign bubble_s    = Flush | hz.Mux_Select_Stall;
    assign pc_plus4_s  = PC + {{(WIDTH-3){1'b0}}, 3'b100};   // wraps modulo 2^WIDTH
    assign ifid_d_s    = {pc_plus4_s, IF_Instr};
    assign idex_d_s    = {ID_EX_PC4_d(), ID_ReadData1, ID_ReadData2, ID_SignExt,
                          field_rs(IF_ID_Instr[31:0]), field_rt(IF_ID_Instr[31:0]),
                          field_rd(IF_ID_Instr[31:0])};

    function automatic logic [WIDTH-1:0] ID_EX_PC4_d();
        return IF_ID_PC4;
    endfunction

    pipe_reg_en #(.W(WIDTH), .RESET_VAL(RESET_PC)) u_pc (
        .clk(clk), .rst(reset), .en(pc_en_s), .clr(1'b0), .d(PC_next), .q(PC)
    );

    // Flush clears IF/ID to a NOP even if IF_ID_Write is low.
    pipe_reg_en #(.W(IFID_W)) u_ifid (
        .clk(clk), .rst(reset), .en(hz.IF_ID_Write), .clr(Flush), .d(ifid_d_s), .q(ifid_q_s)
    );

    // ID/EX data always advances; a bubble only zeroes control.
    pipe_reg_en #(.W(IDEX_W)) u_idex_data (
        .clk(clk), .rst(reset), .en(1'b1), .clr(1'b0), .d(idex_d_s), .q(idex_q_s)
    );

    pipe_reg_en #(.W(CTRL_W)) u_idex_ctrl (
        .clk(clk), .rst(reset), .en(1'b1), .clr(bubble_s), .d(ID_Ctrl), .q(ID_EX_Ctrl)
    );

    assign IF_ID_PC4       = ifid_q_s[IFID_W-1:WIDTH];
    assign IF_ID_Instr     = ifid_q_s[WIDTH-1:0];
    assign ID_EX_PC4       = idex_q_s[IDEX_W-1:3*WIDTH+15];
    assign ID_EX_ReadData1 = idex_q_s[3*WIDTH+14:2*WIDTH+15];
    assign ID_EX_ReadData2 = idex_q_s[2*WIDTH+14:WIDTH+15];
    assign ID_EX_SignExt   = idex_q_s[WIDTH+14:15];
    assign ID_EX_RegRs     = idex_q_s[14:10];
    assign idex_rt_s       = idex_q_s[9:5];
    assign ID_EX_RegRd     = idex_q_s[4:0];

    // Hazard-unit feedback: zero-latency slices of the registered values.
    assign hz.IF_ID_RegRs   = field_rs(IF_ID_Instr[31:0]);
    assign hz.IF_ID_RegRt   = field_rt(IF_ID_Instr[31:0]);
    assign hz.ID_EX_RegRt   = idex_rt_s;
    assign hz.ID_EX_MemRead = ID_EX_Ctrl[CTRL_MEMREAD];

    // Stall FSM with registered Stall_Active and saturating counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= ST_RUN;
            stall_active_r <= 1'b0;
            stall_count_r  <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_RUN, ST_STALL: begin
                    if (stall_hit_s) begin
                        state_r        <= ST_STALL;
                        stall_active_r <= 1'b1;
                    end else begin
                        state_r        <= ST_RUN;
                        stall_active_r <= 1'b0;
                    end
                end
                default: begin
                    state_r        <= ST_RUN;
                    stall_active_r <= 1'b0;
                end
            endcase
            if (stall_hit_s) begin
                stall_count_r <= sat_inc(stall_count_r);
            end else begin
                stall_count_r <= stall_count_r;
            end
        end
    end

    assign Stall_Active = stall_active_r;
    assign Stall_Count  = stall_count_r;

endmodule

// File: tb/tb_pipeline_stall_regs.sv
module tb_pipeline_stall_regs;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    logic              clk;
    logic              reset;
    logic              Flush;
    logic [WIDTH-1:0]  PC_next;
    logic [WIDTH-1:0]  IF_Instr;
    logic [8:0]        ID_Ctrl;
    logic [WIDTH-1:0]  ID_ReadData1;
    logic [WIDTH-1:0]  ID_ReadData2;
    logic [WIDTH-1:0]  ID_SignExt;
    logic [WIDTH-1:0]  PC;
    logic [WIDTH-1:0]  IF_ID_PC4;
    logic [WIDTH-1:0]  IF_ID_Instr;
    logic [8:0]        ID_EX_Ctrl;
    logic [4:0]        ID_EX_RegRs;
    logic [4:0]        ID_EX_RegRd;
    logic [WIDTH-1:0]  ID_EX_PC4;
    logic [WIDTH-1:0]  ID_EX_ReadData1;
    logic [WIDTH-1:0]  ID_EX_ReadData2;
    logic [WIDTH-1:0]  ID_EX_SignExt;
    logic              Stall_Active;
    logic [CNT_W-1:0]  Stall_Count;

    int checks_total;
    int checks_passed;

    pipeline_stall_regs_if hz ();

    pipeline_stall_regs #(
        .WIDTH(WIDTH), .CNT_W(CNT_W), .RESET_PC(32'h0000_0000)
    ) dut (
        .clk(clk), .reset(reset), .hz(hz), .Flush(Flush),
        .PC_next(PC_next), .IF_Instr(IF_Instr), .ID_Ctrl(ID_Ctrl),
        .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2), .ID_SignExt(ID_SignExt),
        .PC(PC), .IF_ID_PC4(IF_ID_PC4), .IF_ID_Instr(IF_ID_Instr),
        .ID_EX_Ctrl(ID_EX_Ctrl), .ID_EX_RegRs(ID_EX_RegRs), .ID_EX_RegRd(ID_EX_RegRd),
        .ID_EX_PC4(ID_EX_PC4), .ID_EX_ReadData1(ID_EX_ReadData1),
        .ID_EX_ReadData2(ID_EX_ReadData2), .ID_EX_SignExt(ID_EX_SignExt),
        .Stall_Active(Stall_Active), .Stall_Count(Stall_Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        reset = 1'b1;
        Flush = 1'b0;
        hz.PCWrite = 1'b0;
        hz.IF_ID_Write = 1'b0;
        hz.Mux_Select_Stall = 1'b0;
        PC_next = 32'h0;
        IF_Instr = 32'h0;
        ID_Ctrl = 9'h000;
        ID_ReadData1 = 32'h0;
        ID_ReadData2 = 32'h0;
        ID_SignExt = 32'h0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_pc", PC, 32'h0);
        check("rst_ifid_instr", IF_ID_Instr, 32'h0);
        check("rst_idex_ctrl", ID_EX_Ctrl, 9'h000);
        check("rst_count", Stall_Count, 4'd0);
        check("rst_active", Stall_Active, 1'b0);

        // Normal flow: fetch lw $9,4($2)
        hz.PCWrite = 1'b1;
        hz.IF_ID_Write = 1'b1;
        PC_next = 32'h4;
        IF_Instr = 32'h8C49_0004;
        ID_Ctrl = 9'h000;
        tick();
        check("nf_pc", PC, 32'h4);
        check("nf_rs", hz.IF_ID_RegRs, 5'd2);
        check("nf_rt", hz.IF_ID_RegRt, 5'd9);
        check("nf_pc4", IF_ID_PC4, 32'h4);

        // lw moves to EX with lw control; add $10,$8,$9 enters ID
        PC_next = 32'h8;
        IF_Instr = 32'h0109_5020;
        ID_Ctrl = 9'h1C8;
        ID_ReadData1 = 32'h1111_1111;
        ID_ReadData2 = 32'h2222_2222;
        ID_SignExt = 32'h0000_0004;
        tick();
        check("nf2_ex_rt", hz.ID_EX_RegRt, 5'd9);
        check("nf2_ex_rs", ID_EX_RegRs, 5'd2);
        check("nf2_memread", hz.ID_EX_MemRead, 1'b1);
        check("nf2_ex_ctrl", ID_EX_Ctrl, 9'h1C8);
        check("nf2_ex_pc4", ID_EX_PC4, 32'h4);
        check("nf2_ex_rd1", ID_EX_ReadData1, 32'h1111_1111);
        check("nf2_ex_se", ID_EX_SignExt, 32'h4);
        check("nf2_pc", PC, 32'h8);
        check("nf2_if_pc4", IF_ID_PC4, 32'h8);

        // Load-use stall for one cycle
        hz.PCWrite = 1'b0;
        hz.IF_ID_Write = 1'b0;
        hz.Mux_Select_Stall = 1'b1;
        PC_next = 32'hC;
        IF_Instr = 32'hDEAD_BEEF;
        ID_Ctrl = 9'h106;
        tick();
        check("st_pc", PC, 32'h8);
        check("st_instr", IF_ID_Instr, 32'h0109_5020);
        check("st_ctrl", ID_EX_Ctrl, 9'h000);
        check("st_memread", hz.ID_EX_MemRead, 1'b0);
        check("st_active", Stall_Active, 1'b1);
        check("st_count", Stall_Count, 4'd1);
        check("st_rd", ID_EX_RegRd, 5'd10);

        // Release
        hz.PCWrite = 1'b1;
        hz.IF_ID_Write = 1'b1;
        hz.Mux_Select_Stall = 1'b0;
        IF_Instr = 32'h0000_0000;
        tick();
        check("rl_ctrl", ID_EX_Ctrl, 9'h106);
        check("rl_active", Stall_Active, 1'b0);
        check("rl_count", Stall_Count, 4'd1);
        check("rl_pc", PC, 32'hC);
        check("rl_pc4", IF_ID_PC4, 32'hC);

        // Flush and stall together
        Flush = 1'b1;
        hz.Mux_Select_Stall = 1'b1;
        hz.PCWrite = 1'b0;
        PC_next = 32'h40;
        IF_Instr = 32'hAAAA_5555;
        tick();
        check("fl_pc", PC, 32'h40);
        check("fl_instr", IF_ID_Instr, 32'h0);
        check("fl_pc4", IF_ID_PC4, 32'h0);
        check("fl_ctrl", ID_EX_Ctrl, 9'h000);
        check("fl_count", Stall_Count, 4'd1);
        check("fl_active", Stall_Active, 1'b0);

        // Saturation: 20 stall cycles starting from count 1
        Flush = 1'b0;
        hz.IF_ID_Write = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 13) check("sat_13", Stall_Count, 4'd14);
            if (i == 14) check("sat_14", Stall_Count, 4'd15);
        end
        check("sat_20", Stall_Count, 4'd15);
        check("sat_active", Stall_Active, 1'b1);
        check("sat_pc_hold", PC, 32'h40);

        // PC+4 wrap
        hz.Mux_Select_Stall = 1'b0;
        hz.PCWrite = 1'b1;
        PC_next = 32'hFFFF_FFFC;
        tick();
        check("wr_pc", PC, 32'hFFFF_FFFC);
        hz.IF_ID_Write = 1'b1;
        IF_Instr = 32'h1234_5678;
        PC_next = 32'h100;
        tick();
        check("wr_pc4", IF_ID_PC4, 32'h0);
        check("wr_instr", IF_ID_Instr, 32'h1234_5678);

        // Asynchronous reset in the middle of a stall
        hz.PCWrite = 1'b0;
        hz.IF_ID_Write = 1'b0;
        hz.Mux_Select_Stall = 1'b1;
        ID_Ctrl = 9'h1FF;
        tick();
        check("pre_active", Stall_Active, 1'b1);
        check("pre_pc", PC, 32'h100);
        reset = 1'b1;
        #1;
        check("ar_pc", PC, 32'h0);
        check("ar_instr", IF_ID_Instr, 32'h0);
        check("ar_ctrl", ID_EX_Ctrl, 9'h000);
        check("ar_count", Stall_Count, 4'd0);
        check("ar_active", Stall_Active, 1'b0);
        #1;
        reset = 1'b0;
        hz.Mux_Select_Stall = 1'b0;
        tick();
        check("post_ctrl", ID_EX_Ctrl, 9'h1FF);
        check("post_count", Stall_Count, 4'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_regs.md
Name: pipeline_stall_regs

Overview:
Consumer side of the load-use hazard interface. It holds the PC register, the IF/ID register and the ID/EX register, and it acts on the hazard signals PCWrite, IF_ID_Write and Mux_Select_Stall. On a stall it freezes PC and IF/ID and inserts a bubble into ID/EX. It also returns the ID_EX_MemRead, ID_EX_RegRt, IF_ID_RegRs and IF_ID_RegRt fields that the hazard unit compares, and it keeps a saturating stall-cycle counter.

Parameters:
WIDTH, 32, datapath/PC/instruction width
CNT_W, 16, stall counter width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
PCWrite  input  1  1 = PC may update
IF_ID_Write  input  1  1 = IF/ID may capture
Mux_Select_Stall  input  1  1 = zero ID/EX control fields (bubble)
Flush  input  1  taken branch/jump redirect
PC_next  input  WIDTH  next PC from fetch mux
IF_Instr  input  WIDTH  instruction from instruction memory
ID_Ctrl  input  9  {RegWrite, MemtoReg, MemRead, MemWrite, Branch, ALUSrc, RegDst, ALUOp[1:0]}
ID_ReadData1  input  WIDTH  register file port 1
ID_ReadData2  input  WIDTH  register file port 2
ID_SignExt  input  WIDTH  sign-extended immediate
PC  output  WIDTH  current fetch PC
IF_ID_PC4  output  WIDTH  PC+4 of instruction in ID
IF_ID_Instr  output  WIDTH  instruction in ID
IF_ID_RegRs  output  5  IF_ID_Instr[25:21]
IF_ID_RegRt  output  5  IF_ID_Instr[20:16]
ID_EX_Ctrl  output  9  registered control, same packing as ID_Ctrl
ID_EX_MemRead  output  1  ID_EX_Ctrl MemRead bit
ID_EX_RegRs  output  5  captured Rs
ID_EX_RegRt  output  5  captured Rt
ID_EX_RegRd  output  5  captured Rd
ID_EX_PC4  output  WIDTH  captured PC+4
ID_EX_ReadData1  output  WIDTH  captured operand 1
ID_EX_ReadData2  output  WIDTH  captured operand 2
ID_EX_SignExt  output  WIDTH  captured immediate
Stall_Active  output  1  registered: last edge inserted a hazard bubble
Stall_Count  output  CNT_W  saturating count of hazard stall cycles

Behaviour:
- Reset (async, any time, including mid-stall):
  - PC = RESET_PC.
  - Every other register = 0. IF_ID_Instr = 0 (sll $0 NOP).
  - FSM returns to RUN.
- PC register, updated every posedge:
  - Flush=1: PC <= PC_next. Flush overrides PCWrite.
  - else PCWrite=1: PC <= PC_next.
  - else hold.
- IF/ID register, priority Flush > IF_ID_Write:
  - Flush=1: IF_ID_Instr <= 0 and IF_ID_PC4 <= 0.
  - else IF_ID_Write=1: IF_ID_Instr <= IF_Instr and IF_ID_PC4 <= PC + 4. The add wraps modulo 2^WIDTH.
  - else hold.
- IF_ID_RegRs and IF_ID_RegRt are combinational field slices of the registered instruction, giving zero extra latency to the hazard unit.
- ID/EX register:
  - Data fields (PC4, ReadData, SignExt, Rs/Rt/Rd) load every cycle. Rs/Rt/Rd come from IF_ID_Instr.
  - Control: if Mux_Select_Stall=1 or Flush=1, ID_EX_Ctrl <= 0; else ID_EX_Ctrl <= ID_Ctrl.
  - A bubble therefore carries stale data with zero control and performs no write or memory access.
- FSM, two states:
  - RUN -> STALL when Mux_Select_Stall=1 and Flush=0.
  - STALL -> STALL while that condition persists.
  - STALL -> RUN otherwise.
  - Stall_Active = 1 in STALL.
- Stall_Count:
  - Increments on each edge where Mux_Select_Stall=1 and Flush=0.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Flush-induced bubbles are not counted.
- Simultaneous Flush and Mux_Select_Stall: Flush wins. PC redirects, IF/ID becomes NOP, ID/EX gets a bubble, no stall is counted.
- Inconsistent inputs (e.g. Mux_Select_Stall=1 while IF_ID_Write=1) are not corrected. Each signal acts independently as above.
- Latency: one cycle from any input to its registered output.

Decomposition:
- Shared package cpu_pkg:
  - Control bit index constants CTRL_REGWRITE..CTRL_ALUOP and CTRL_W=9.
  - NOP_INSTR=0.
  - Field slice positions RS_HI/LO, RT_HI/LO, RD_HI/LO.
- One natural sub-module: pipe_reg_en, a WIDTH-parameterised register with enable and synchronous clear and async reset. Instantiate it for PC, IF/ID and ID/EX.

Test Plan:
1. Reset mid-stream: assert reset while Mux_Select_Stall=1 -> PC=RESET_PC, IF_ID_Instr=0, ID_EX_Ctrl=0, Stall_Count=0, Stall_Active=0, all asynchronously before the next edge.
2. Normal flow: PCWrite=IF_ID_Write=1, PC_next=0x4, IF_Instr=0x8C490004 (lw $9,4($2)) -> next edge PC=4, IF_ID_RegRs=2, IF_ID_RegRt=9. Following edge ID_EX_RegRt=9 and ID_EX_MemRead follows the MemRead bit of ID_Ctrl.
3. Load-use stall: PCWrite=IF_ID_Write=0, Mux_Select_Stall=1 for one cycle -> PC and IF_ID_Instr unchanged, ID_EX_Ctrl=0, Stall_Active=1, Stall_Count=1. Next cycle with stall released, ID_EX_Ctrl=ID_Ctrl and Stall_Active=0.
4. Flush vs stall collision: Flush=1, Mux_Select_Stall=1, PCWrite=0, PC_next=0x40 -> PC=0x40, IF_ID_Instr=0, ID_EX_Ctrl=0, Stall_Count unchanged.
5. Saturation: CNT_W=4, hold stall for 20 cycles -> Stall_Count reaches 15 and stays 15.
6. Wrap: PC=0xFFFFFFFC with IF_ID_Write=1 -> IF_ID_PC4=0x00000000.
